// File: rtl/cam_bus_emitter.sv
// OV7670-style 8-bit parallel pixel bus transmitter (RGB565, two bytes per pixel).
// Define CAM_EXT_PIXEL_EN to take pixels from Pix_in/Pix_req instead of the internal colour bars.
module cam_bus_emitter #(
  parameter int H_ACTIVE = 160,
  parameter int V_ACTIVE = 120,
  parameter int H_BLANK  = 16,
  parameter int V_FRONT  = 2,
  parameter int V_BACK   = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Enable,
`ifdef CAM_EXT_PIXEL_EN
  input  logic [15:0] Pix_in,
  output logic        Pix_req,
`endif
  output logic        Pclk,
  output logic        Href,
  output logic        Vsync,
  output logic [7:0]  Data,
  output logic        Frame_done,
  output logic [7:0]  Frame_cnt
);

  localparam int LINE_TICKS = 2 * H_ACTIVE + H_BLANK;
  localparam int TICK_W     = (LINE_TICKS > 1) ? $clog2(LINE_TICKS) : 1;
  localparam int V_MAX_01   = (V_FRONT > V_ACTIVE) ? V_FRONT : V_ACTIVE;
  localparam int V_MAX      = (V_MAX_01 > V_BACK) ? V_MAX_01 : V_BACK;
  localparam int LINE_W     = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(LINE_TICKS - 1);
  localparam logic [TICK_W:0]   HREF_TICKS = (TICK_W + 1)'(2 * H_ACTIVE);
  localparam logic [LINE_W-1:0] VF_LAST    = LINE_W'((V_FRONT > 0) ? V_FRONT - 1 : 0);
  localparam logic [LINE_W-1:0] VA_LAST    = LINE_W'((V_ACTIVE > 0) ? V_ACTIVE - 1 : 0);
  localparam logic [LINE_W-1:0] VB_LAST    = LINE_W'((V_BACK > 0) ? V_BACK - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_VFRONT,
    S_ACTIVE,
    S_VBACK
  } state_t;

  localparam state_t FIRST_STATE = (V_FRONT > 0) ? S_VFRONT : S_ACTIVE;

  logic              pclk_q, pclk_d;
  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              href_q, href_d;
  logic              vsync_q, vsync_d;
  logic [7:0]        data_q, data_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  logic [LINE_W-1:0] line_last;
  logic              frame_end;
  logic              in_line;

`ifdef CAM_EXT_PIXEL_EN
  logic [7:0] pix_lo_q, pix_lo_d;
  logic       pix_req_q, pix_req_d;
`else
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int PIB_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [PIB_W-1:0] PIB_LAST = PIB_W'(BAR_W - 1);

  logic [2:0]       bar_q, bar_d;
  logic [PIB_W-1:0] pib_q, pib_d;
  logic [15:0]      colour;

  function automatic logic [15:0] bar_colour(input logic [2:0] bar);
    case (bar)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      3'd5:    return 16'hF800;
      3'd6:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction
`endif

  always_comb begin
    pclk_d       = ~pclk_q;
    state_d      = state_q;
    tick_d       = tick_q;
    line_d       = line_q;
    href_d       = href_q;
    vsync_d      = vsync_q;
    data_d       = data_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    frame_end    = 1'b0;
    in_line      = 1'b0;
`ifdef CAM_EXT_PIXEL_EN
    pix_lo_d     = pix_lo_q;
    pix_req_d    = 1'b0;
`else
    bar_d        = bar_q;
    pib_d        = pib_q;
    colour       = 16'h0000;
`endif

    case (state_q)
      S_VFRONT: line_last = VF_LAST;
      S_ACTIVE: line_last = VA_LAST;
      default:  line_last = VB_LAST;
    endcase

    // Everything except Pclk advances only on the edge where Pclk rises.
    if (!pclk_q) begin
      if (state_q == S_IDLE) begin
        if (Enable) begin
          state_d = FIRST_STATE;
          tick_d  = '0;
          line_d  = '0;
        end
      end else if (tick_q != TICK_LAST) begin
        tick_d = tick_q + TICK_W'(1);
      end else begin
        tick_d = '0;
        if (line_q != line_last) begin
          line_d = line_q + LINE_W'(1);
        end else begin
          line_d = '0;
          if (state_q == S_VFRONT)
            state_d = S_ACTIVE;
          else if (state_q == S_ACTIVE && V_BACK > 0)
            state_d = S_VBACK;
          else
            frame_end = 1'b1;
        end
      end

      if (frame_end) begin
        frame_done_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + 8'd1;
        state_d      = Enable ? FIRST_STATE : S_IDLE;
      end

      in_line = (state_d == S_ACTIVE) && ({1'b0, tick_d} < HREF_TICKS);
      vsync_d = (state_d == S_ACTIVE);
      href_d  = in_line;

`ifdef CAM_EXT_PIXEL_EN
      if (in_line && !tick_d[0]) begin
        pix_req_d = 1'b1;
        pix_lo_d  = Pix_in[7:0];
        data_d    = Pix_in[15:8];
      end else if (in_line) begin
        data_d = pix_lo_q;
      end else begin
        data_d = '0;
      end
`else
      // Bar position is carried as counters so no divider is needed per byte.
      if (tick_d == '0) begin
        bar_d = '0;
        pib_d = '0;
      end else if (in_line && !tick_d[0]) begin
        if (pib_q == PIB_LAST) begin
          pib_d = '0;
          bar_d = bar_q + 3'd1;
        end else begin
          pib_d = pib_q + PIB_W'(1);
        end
      end
      colour = bar_colour(bar_d);
      if (in_line)
        data_d = tick_d[0] ? colour[7:0] : colour[15:8];
      else
        data_d = '0;
`endif
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pclk_q       <= 1'b0;
      state_q      <= S_IDLE;
      tick_q       <= '0;
      line_q       <= '0;
      href_q       <= 1'b0;
      vsync_q      <= 1'b0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
`ifdef CAM_EXT_PIXEL_EN
      pix_lo_q     <= '0;
      pix_req_q    <= 1'b0;
`else
      bar_q        <= '0;
      pib_q        <= '0;
`endif
    end else begin
      pclk_q       <= pclk_d;
      state_q      <= state_d;
      tick_q       <= tick_d;
      line_q       <= line_d;
      href_q       <= href_d;
      vsync_q      <= vsync_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
`ifdef CAM_EXT_PIXEL_EN
      pix_lo_q     <= pix_lo_d;
      pix_req_q    <= pix_req_d;
`else
      bar_q        <= bar_d;
      pib_q        <= pib_d;
`endif
    end
  end

  assign Pclk       = pclk_q;
  assign Href       = href_q;
  assign Vsync      = vsync_q;
  assign Data       = data_q;
  assign Frame_done = frame_done_q;
  assign Frame_cnt  = frame_cnt_q;
`ifdef CAM_EXT_PIXEL_EN
  assign Pix_req    = pix_req_q;
`endif

endmodule

// File: tb/tb_cam_bus_emitter.sv
// Bench for cam_bus_emitter: frame-position reference model plus directed and random scenarios.
module tb_cam_bus_emitter;

  localparam int HA = 8;
  localparam int HB = 4;
  localparam int VA = 2;
  localparam int VF = 1;
  localparam int VB = 1;
  localparam int LT = 2 * HA + HB;
  localparam int FT = (VF + VA + VB) * LT;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Enable = 1'b0;
  logic       Pclk, Href, Vsync, Frame_done;
  logic [7:0] Data, Frame_cnt;
`ifdef CAM_EXT_PIXEL_EN
  logic [15:0] Pix_in = 16'h1234;
  logic        Pix_req;
`endif

  cam_bus_emitter #(
    .H_ACTIVE(HA),
    .V_ACTIVE(VA),
    .H_BLANK (HB),
    .V_FRONT (VF),
    .V_BACK  (VB)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Enable    (Enable),
`ifdef CAM_EXT_PIXEL_EN
    .Pix_in    (Pix_in),
    .Pix_req   (Pix_req),
`endif
    .Pclk      (Pclk),
    .Href      (Href),
    .Vsync     (Vsync),
    .Data      (Data),
    .Frame_done(Frame_done),
    .Frame_cnt (Frame_cnt)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [15:0] COLOURS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [7:0]  PAT [20] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                            8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'h00, 8'h00};

  // Reference model: position within the frame as a plain tick index.
  bit         m_pclk = 0, m_run = 0, m_done = 0, m_href = 0, m_vsync = 0, m_req = 0;
  int         m_t = 0, m_line, m_col;
  logic [7:0] m_cnt = 0, m_data = 0, m_lo = 0;
  logic [15:0] m_colour;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_pclk = 0; m_run = 0; m_t = 0; m_cnt = 0; m_done = 0;
      m_href = 0; m_vsync = 0; m_data = 0; m_req = 0;
    end else begin
      m_done = 0;
      m_req  = 0;
      if (!m_pclk) begin
        if (!m_run) begin
          if (Enable) begin m_run = 1; m_t = 0; end
        end else if (m_t == FT - 1) begin
          m_done = 1; m_cnt++; m_t = 0; m_run = Enable;
        end else begin
          m_t++;
        end
        m_line  = m_t / LT;
        m_col   = m_t % LT;
        m_vsync = m_run && m_line >= VF && m_line < VF + VA;
        m_href  = m_vsync && m_col < 2 * HA;
        if (!m_href) m_data = 8'h00;
        else begin
`ifdef CAM_EXT_PIXEL_EN
          if (m_col % 2 == 0) begin
            m_req = 1; m_lo = Pix_in[7:0]; m_data = Pix_in[15:8];
          end else m_data = m_lo;
`else
          m_colour = COLOURS[(m_col / 2) / (HA / 8)];
          m_data   = (m_col % 2 == 1) ? m_colour[7:0] : m_colour[15:8];
`endif
        end
      end
      m_pclk = ~m_pclk;
    end
  end

`ifdef CAM_EXT_PIXEL_EN
  always @(negedge Clk) if (Pix_req) Pix_in = Pix_in + 16'd1;
`endif

  bit chk_en = 0;
  always @(negedge Clk) begin
    #1;
    if (chk_en) begin
      check_eq("pclk", Pclk, m_pclk);
      check_eq("href", Href, m_href);
      check_eq("vsync", Vsync, m_vsync);
      check_eq("data", Data, m_data);
      check_eq("frame_done", Frame_done, m_done);
      check_eq("frame_cnt", Frame_cnt, m_cnt);
`ifdef CAM_EXT_PIXEL_EN
      check_eq("pix_req", Pix_req, m_req);
`endif
    end
  end

  task automatic hold_reset();
    @(negedge Clk);
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic release_and_time_href(output int n);
    Enable = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (Href !== 1'b1 && n < 400);
  endtask

  int n, cnt, nd, toggles, reqs;
  bit any_out, prev_pclk;

  initial begin
    repeat (3) @(negedge Clk);
    chk_en = 1;
    #1;
    check_eq("rst_pclk", Pclk, 0);
    check_eq("rst_href", Href, 0);
    check_eq("rst_vsync", Vsync, 0);
    check_eq("rst_data", Data, 0);
    check_eq("rst_done", Frame_done, 0);
    check_eq("rst_cnt", Frame_cnt, 0);

    // Frame timing and colour bars
    release_and_time_href(n);
    check_eq("first_href_clk", n, 2 * LT + 1);
    for (int k = 0; k < 20; k++) begin
      @(negedge Pclk);
      #1;
`ifndef CAM_EXT_PIXEL_EN
      check_eq("pattern", Data, PAT[k]);
`endif
    end
    n = 0;
    while (Href !== 1'b1 && n < 200) begin @(negedge Clk); n++; end
    cnt = 0;
    while (Href === 1'b1 && cnt < 200) begin cnt++; @(negedge Clk); end
    check_eq("href_len", cnt, 4 * HA);
    n = 0;
    while (Frame_done !== 1'b1 && n < 400) begin @(negedge Clk); n++; end
    cnt = 0; reqs = 0;
    do begin
      @(negedge Clk);
      cnt++;
`ifdef CAM_EXT_PIXEL_EN
      if (Pix_req === 1'b1) reqs++;
`endif
    end while (Frame_done !== 1'b1 && cnt < 400);
    check_eq("done_period", cnt, 2 * FT);
`ifdef CAM_EXT_PIXEL_EN
    check_eq("reqs_per_frame", reqs, VA * HA);
`endif
    n = 0;
    while (Vsync !== 1'b1 && n < 400) begin @(negedge Clk); n++; end
    cnt = 0;
    while (Vsync === 1'b1 && cnt < 400) begin cnt++; @(negedge Clk); end
    check_eq("vsync_len", cnt, 2 * VA * LT);

    // Enable dropped mid-frame
    hold_reset();
    Enable = 1'b1;
    Rst = 1'b0;
    repeat (61) @(negedge Clk);
    Enable = 1'b0;
    nd = 0;
    repeat (400) begin
      @(negedge Clk);
      if (Frame_done === 1'b1) nd++;
    end
    check_eq("drop_done_count", nd, 1);
    check_eq("drop_frame_cnt", Frame_cnt, 1);
    any_out = 0; toggles = 0; prev_pclk = Pclk;
    repeat (100) begin
      @(negedge Clk);
      if (Href !== 1'b0 || Vsync !== 1'b0 || Data !== 8'h00) any_out = 1;
      if (Pclk !== prev_pclk) toggles++;
      prev_pclk = Pclk;
    end
    check_eq("idle_outputs", any_out, 0);
    check_eq("idle_pclk_toggles", toggles, 100);

    // Reset during an active line
    Enable = 1'b1;
    n = 0;
    while (Href !== 1'b1 && n < 400) begin @(negedge Clk); n++; end
    repeat (5) @(negedge Clk);
    Rst = 1'b1;
    #1;
    check_eq("midrst_pclk", Pclk, 0);
    check_eq("midrst_href", Href, 0);
    check_eq("midrst_vsync", Vsync, 0);
    check_eq("midrst_data", Data, 0);
    check_eq("midrst_cnt", Frame_cnt, 0);
    release_and_time_href(n);
    check_eq("rst_first_href_clk", n, 2 * LT + 1);

    // Frame counter wrap
    hold_reset();
    Enable = 1'b1;
    Rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 256 * 2 * FT + 400 && nd < 256; i++) begin
      @(negedge Clk);
      if (Frame_done === 1'b1) begin
        nd++;
        if (nd == 255) check_eq("cnt_255", Frame_cnt, 8'hFF);
        if (nd == 256) check_eq("cnt_wrap", Frame_cnt, 8'h00);
      end
    end
    check_eq("wrap_reached", nd, 256);

    // Random Enable toggling and reset pulses
    repeat (30) begin
      @(negedge Clk);
      if ($urandom_range(0, 9) == 0) begin
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
      end else begin
        Enable = 1'($urandom_range(0, 1));
      end
      repeat ($urandom_range(1, 300)) @(negedge Clk);
    end

    repeat (2) @(negedge Clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cam_bus_emitter.md
Name: cam_bus_emitter

Overview:
- Transmitter side of the OV7670-style 8-bit parallel pixel bus.
- Generates Pclk, Href, Vsync and Data carrying RGB565 pixels, two bytes per pixel.
- Used as a camera stand-in on the Nexys4 and in simulation, driving the capture path with known frames.
- Default pixel source is an internal 8-bar colour pattern.

Parameters:
H_ACTIVE, 160, pixels per active line; must be a multiple of 8
V_ACTIVE, 120, active lines per frame
H_BLANK, 16, Pclk periods with Href low after each line's active bytes
V_FRONT, 2, full blank lines before active lines
V_BACK, 2, full blank lines after active lines

Ports:
Clk  in  1  system clock
Rst  in  1  asynchronous, active-high reset
Enable  in  1  start or continue frames
Pclk  out  1  pixel clock, Clk/2
Href  out  1  high while a line's active bytes are on Data
Vsync  out  1  high for the whole active-line window of a frame
Data  out  8  pixel byte
Frame_done  out  1  one-Clk pulse at end of frame
Frame_cnt  out  8  completed-frame count, wraps

Behaviour:
- Reset values: Pclk=0, Href=0, Vsync=0, Data=0, Frame_done=0, Frame_cnt=0, state IDLE.
- Rst assertion mid-frame aborts the frame immediately; on release, restart from IDLE.
- Pclk toggles every Clk after reset, so it is free-running in all states.
- Data, Href and Vsync are registered and update only on the Clk edge where Pclk goes 0->1. They are stable across the Pclk falling edge, where the sink samples.
- One "tick" = one Pclk period = 2 Clk.
- Line = 2*H_ACTIVE + H_BLANK ticks.
- Frame = (V_FRONT + V_ACTIVE + V_BACK) lines.
- States:
  - IDLE: all outputs low. Move to VFRONT at the next tick boundary where Enable=1.
  - VFRONT: V_FRONT lines with Vsync=0, Href=0.
  - ACTIVE: V_ACTIVE lines with Vsync=1. Per line, Href=1 for 2*H_ACTIVE ticks, then Href=0 for H_BLANK ticks. Vsync rises on the first tick of the first active line and falls after the last blank tick of the last active line.
  - VBACK: V_BACK lines with Vsync=0, Href=0.
  - At the last tick of VBACK: pulse Frame_done for 1 Clk and increment Frame_cnt (0xFF -> 0x00). Then go to VFRONT if Enable=1, else IDLE.
- Enable deasserted mid-frame has no effect; the current frame always completes.
- If V_FRONT=0 or V_BACK=0, the corresponding state is skipped.
- Byte order per pixel:
  - First byte = {R[4:0], G[5:3]}.
  - Second byte = {G[2:0], B[4:0]}.
- Data=0 whenever Href=0.
- Colour pattern:
  - Bar width = H_ACTIVE/8 pixels. The bar counter and pixel-in-bar counter reset at the start of each line.
  - Colours, left to right: 0xFFFF, 0xFFE0, 0x07FF, 0x07E0, 0xF81F, 0xF800, 0x001F, 0x0000.
  - The pattern is identical on every line and every frame.
- Counters are sized with $clog2 of their maximum value. No arithmetic overflow is permitted within a frame.

Optional Feature:
- Macro: CAM_EXT_PIXEL_EN.
- Defined:
  - Adds input Pix_in[15:0] (RGB565) and output Pix_req (1 Clk pulse).
  - Pix_req pulses on the Clk edge that emits each pixel's first byte.
  - Pix_in is sampled on that same edge; both bytes of that pixel come from the sampled value.
  - No backpressure: the source must hold valid data whenever Pix_req pulses.
  - The colour pattern logic is removed.
- Undefined: ports absent; internal colour bars are used.

Test Plan:
All scenarios use H_ACTIVE=8, H_BLANK=4, V_ACTIVE=2, V_FRONT=1, V_BACK=1, giving line = 20 ticks and frame = 80 ticks = 160 Clk.
1. Reset, then Enable=1 held:
   - First Href rise occurs 20 ticks after leaving IDLE.
   - Href is high for 16 ticks per line; Vsync is high for exactly 40 ticks.
   - Frame_done pulses every 160 Clk.
2. Pattern check, sampled on Pclk falling edges in line 1: bytes are FF,FF, FF,E0, 07,FF, 07,E0, F8,1F, F8,00, 00,1F, 00,00; Data=0 during the 4 blank ticks.
3. Enable dropped at tick 30 of frame 0:
   - The frame completes and Frame_done pulses once.
   - Frame_cnt = 1.
   - Outputs stay low in IDLE while Pclk keeps toggling.
4. Rst pulsed during an active line:
   - All outputs go to reset values immediately.
   - After release with Enable=1, a full VFRONT line precedes the next Href.
5. Run 256 frames: Frame_cnt wraps 0xFF -> 0x00 on the 256th Frame_done.
6. With CAM_EXT_PIXEL_EN defined and Pix_in = a counter incremented on each Pix_req:
   - Bytes carry successive values in order: high byte, then low byte.
   - Pix_req count = 16 per frame.
